// File: rtl/cache_axi_sched.sv
`default_nettype none
// ============================================================================
// cache_axi_sched: serialises cache fills and victim writebacks onto one
// AXI4 master as single INCR line bursts, writeback first.   Rev 1.0
// ============================================================================
module cache_axi_sched #(
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 64,
   parameter int AXI_ID_WIDTH   = 4,
   parameter int LINE_BEATS     = 4,
   parameter int WR_ID          = 0,
   parameter int RD_ID          = 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          wb_req,
   input  logic [AXI_ADDR_WIDTH-1:0]     wb_addr,
   output logic                          wb_gnt,
   input  logic [AXI_DATA_WIDTH-1:0]     wb_wdata,
   output logic                          wb_wbeat,
   output logic                          wb_done,
   output logic                          wb_err,
   input  logic                          fill_req,
   input  logic [AXI_ADDR_WIDTH-1:0]     fill_addr,
   output logic                          fill_gnt,
   output logic [AXI_DATA_WIDTH-1:0]     fill_rdata,
   output logic                          fill_rvalid,
   output logic                          fill_rlast,
   output logic                          fill_done,
   output logic                          fill_err,
   output logic [AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
   output logic [AXI_ID_WIDTH-1:0]       M_AXI_AWID,
   output logic [1:0]                    M_AXI_AWBURST,
   output logic [2:0]                    M_AXI_AWSIZE,
   output logic [7:0]                    M_AXI_AWLEN,
   output logic                          M_AXI_AWVALID,
   input  logic                          M_AXI_AWREADY,
   output logic [AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
   output logic [AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
   output logic                          M_AXI_WLAST,
   output logic                          M_AXI_WVALID,
   input  logic                          M_AXI_WREADY,
   input  logic [1:0]                    M_AXI_BRESP,
   input  logic [AXI_ID_WIDTH-1:0]       M_AXI_BID,
   input  logic                          M_AXI_BVALID,
   output logic                          M_AXI_BREADY,
   output logic [AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
   output logic [AXI_ID_WIDTH-1:0]       M_AXI_ARID,
   output logic [1:0]                    M_AXI_ARBURST,
   output logic [2:0]                    M_AXI_ARSIZE,
   output logic [7:0]                    M_AXI_ARLEN,
   output logic                          M_AXI_ARVALID,
   input  logic                          M_AXI_ARREADY,
   input  logic [AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
   input  logic [1:0]                    M_AXI_RRESP,
   input  logic [AXI_ID_WIDTH-1:0]       M_AXI_RID,
   input  logic                          M_AXI_RLAST,
   input  logic                          M_AXI_RVALID,
   output logic                          M_AXI_RREADY
);

   localparam int c_bb   = AXI_DATA_WIDTH / 8;
   localparam int c_off  = $clog2(c_bb * LINE_BEATS);
   localparam int c_cw   = $clog2(LINE_BEATS);
   localparam logic [AXI_ADDR_WIDTH-1:0] c_mask =
      ~((AXI_ADDR_WIDTH'(1) << c_off) - AXI_ADDR_WIDTH'(1));
   localparam logic [c_cw-1:0] c_last = c_cw'(LINE_BEATS - 1);
   localparam logic [AXI_ID_WIDTH-1:0] c_wr_id = AXI_ID_WIDTH'(WR_ID);
   localparam logic [AXI_ID_WIDTH-1:0] c_rd_id = AXI_ID_WIDTH'(RD_ID);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_AW   = 3'd1,
      S_W    = 3'd2,
      S_B    = 3'd3,
      S_AR   = 3'd4,
      S_R    = 3'd5
   } state_t;

   state_t                      state_q, state_d;
   logic [AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [c_cw-1:0]             cnt_q, cnt_d;
   logic                        rerr_q, rerr_d;
   logic                        w_wlast;
   logic                        w_rbeat;
   logic                        w_rbeat_err;

   assign w_wlast     = (cnt_q == c_last);
   assign w_rbeat     = (state_q == S_R) && M_AXI_RVALID;
   assign w_rbeat_err = (M_AXI_RRESP != 2'b00) || (M_AXI_RID != c_rd_id);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         cnt_q   <= '0;
         rerr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         rerr_q  <= rerr_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      cnt_d    = cnt_q;
      rerr_d   = rerr_q;
      wb_gnt   = 1'b0;
      fill_gnt = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (wb_req) begin
               wb_gnt  = 1'b1;
               addr_d  = wb_addr & c_mask;
               cnt_d   = '0;
               state_d = S_AW;
            end else if (fill_req) begin
               fill_gnt = 1'b1;
               addr_d   = fill_addr & c_mask;
               cnt_d    = '0;
               rerr_d   = 1'b0;
               state_d  = S_AR;
            end
         end
         S_AW: if (M_AXI_AWREADY) state_d = S_W;
         S_W: begin
            if (M_AXI_WREADY) begin
               cnt_d = cnt_q + 1'b1;
               if (w_wlast) state_d = S_B;
            end
         end
         S_B: if (M_AXI_BVALID) state_d = S_IDLE;
         S_AR: if (M_AXI_ARREADY) state_d = S_R;
         S_R: begin
            if (M_AXI_RVALID) begin
               cnt_d = cnt_q + 1'b1;
               // A non-final beat at the line end means the burst overran; keep it flagged
               if (w_rbeat_err || (!M_AXI_RLAST && (cnt_q == c_last))) rerr_d = 1'b1;
               if (M_AXI_RLAST) state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign M_AXI_AWADDR  = addr_q;
   assign M_AXI_AWID    = c_wr_id;
   assign M_AXI_AWBURST = 2'b01;
   assign M_AXI_AWSIZE  = 3'($clog2(c_bb));
   assign M_AXI_AWLEN   = 8'(LINE_BEATS - 1);
   assign M_AXI_AWVALID = (state_q == S_AW);

   assign M_AXI_WDATA   = wb_wdata;
   assign M_AXI_WSTRB   = {c_bb{1'b1}};
   assign M_AXI_WLAST   = w_wlast;
   assign M_AXI_WVALID  = (state_q == S_W);
   assign wb_wbeat      = M_AXI_WVALID && M_AXI_WREADY;

   assign M_AXI_BREADY  = (state_q == S_B);
   assign wb_done       = M_AXI_BREADY && M_AXI_BVALID;
   assign wb_err        = wb_done && ((M_AXI_BRESP != 2'b00) || (M_AXI_BID != c_wr_id));

   assign M_AXI_ARADDR  = addr_q;
   assign M_AXI_ARID    = c_rd_id;
   assign M_AXI_ARBURST = 2'b01;
   assign M_AXI_ARSIZE  = 3'($clog2(c_bb));
   assign M_AXI_ARLEN   = 8'(LINE_BEATS - 1);
   assign M_AXI_ARVALID = (state_q == S_AR);
   assign M_AXI_RREADY  = (state_q == S_R);

   assign fill_rdata    = M_AXI_RDATA;
   assign fill_rvalid   = w_rbeat;
   assign fill_rlast    = w_rbeat && M_AXI_RLAST;
   assign fill_done     = fill_rlast;
   assign fill_err      = fill_rlast && (rerr_q || w_rbeat_err || (cnt_q != c_last));

endmodule
`default_nettype wire

// File: tb/tb_cache_axi_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_cache_axi_sched: directed bench driving the cache side and an AXI slave
// model, with hand-computed expectations.   Rev 1.0
// ============================================================================
module tb_cache_axi_sched;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wb_req = 1'b0, fill_req = 1'b0;
   logic [31:0] wb_addr = '0, fill_addr = '0;
   logic [63:0] wb_wdata = '0;
   logic        wb_gnt, wb_wbeat, wb_done, wb_err;
   logic        fill_gnt, fill_rvalid, fill_rlast, fill_done, fill_err;
   logic [63:0] fill_rdata;
   logic [31:0] awaddr, araddr;
   logic [3:0]  awid, arid;
   logic [1:0]  awburst, arburst;
   logic [2:0]  awsize, arsize;
   logic [7:0]  awlen, arlen, wstrb;
   logic        awvalid, wlast, wvalid, bready, arvalid, rready;
   logic [63:0] wdata;
   logic        awready = 0, wready = 0, bvalid = 0, arready = 0, rvalid = 0, rlast = 0;
   logic [1:0]  bresp = 0, rresp = 0;
   logic [3:0]  bid = 0, rid = 0;
   logic [63:0] rdata = '0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cache_axi_sched dut (
      .clk(clk), .rst_n(rst_n),
      .wb_req(wb_req), .wb_addr(wb_addr), .wb_gnt(wb_gnt), .wb_wdata(wb_wdata),
      .wb_wbeat(wb_wbeat), .wb_done(wb_done), .wb_err(wb_err),
      .fill_req(fill_req), .fill_addr(fill_addr), .fill_gnt(fill_gnt),
      .fill_rdata(fill_rdata), .fill_rvalid(fill_rvalid), .fill_rlast(fill_rlast),
      .fill_done(fill_done), .fill_err(fill_err),
      .M_AXI_AWADDR(awaddr), .M_AXI_AWID(awid), .M_AXI_AWBURST(awburst),
      .M_AXI_AWSIZE(awsize), .M_AXI_AWLEN(awlen), .M_AXI_AWVALID(awvalid),
      .M_AXI_AWREADY(awready),
      .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast),
      .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
      .M_AXI_BRESP(bresp), .M_AXI_BID(bid), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
      .M_AXI_ARADDR(araddr), .M_AXI_ARID(arid), .M_AXI_ARBURST(arburst),
      .M_AXI_ARSIZE(arsize), .M_AXI_ARLEN(arlen), .M_AXI_ARVALID(arvalid),
      .M_AXI_ARREADY(arready),
      .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RID(rid), .M_AXI_RLAST(rlast),
      .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called in the cycle after wb_gnt; returns in IDLE, mid-cycle.
   task automatic axi_write(input logic [31:0] exp_addr, input logic [63:0] base,
                            input int aw_dly, input bit tog, input logic [1:0] resp,
                            input logic [3:0] id, input bit exp_err);
      int beat = 0;
      int n = 0;
      awready = 1'b0;
      for (int i = 0; i < aw_dly; i++) begin
         #1;
         chk("aw_valid_wait", awvalid, 1);
         chk("aw_addr_stable", awaddr, exp_addr);
         chk("w_before_aw", wvalid, 0);
         tick();
      end
      awready = 1'b1;
      #1;
      chk("aw_valid", awvalid, 1);
      chk("aw_addr", awaddr, exp_addr);
      chk("aw_len", awlen, 3);
      chk("aw_size", awsize, 3);
      chk("aw_burst", awburst, 1);
      chk("aw_id", awid, 0);
      chk("w_before_aw", wvalid, 0);
      tick();
      awready = 1'b0;
      while (beat < 4 && n < 64) begin
         wready   = tog ? n[0] : 1'b1;
         wb_wdata = base + 64'(beat);
         #1;
         chk("w_valid", wvalid, 1);
         chk("w_last", wlast, (beat == 3));
         chk("one_outstanding_fill", fill_gnt, 0);
         if (wready) begin
            chk("w_data", wdata, base + 64'(beat));
            chk("w_strb", wstrb, 8'hff);
            chk("wb_wbeat", wb_wbeat, 1);
            beat++;
         end else begin
            chk("wb_wbeat_idle", wb_wbeat, 0);
         end
         tick();
         n++;
      end
      chk("w_beat_count", beat, 4);
      wready = 1'b0;
      #1;
      chk("w_valid_after_last", wvalid, 0);
      chk("b_ready", bready, 1);
      chk("wb_done_early", wb_done, 0);
      tick();
      bvalid = 1'b1;
      bresp  = resp;
      bid    = id;
      #1;
      chk("wb_done", wb_done, 1);
      chk("wb_err", wb_err, exp_err);
      tick();
      bvalid = 1'b0;
      bresp  = 2'b00;
      bid    = 4'd0;
      #1;
      chk("b_ready_idle", bready, 0);
      chk("wb_done_idle", wb_done, 0);
   endtask

   // Called in the cycle after fill_gnt; returns in IDLE, mid-cycle.
   task automatic axi_read(input logic [31:0] exp_addr, input logic [63:0] base,
                           input int ar_dly, input int nbeats, input int err_beat,
                           input bit exp_err);
      arready = 1'b0;
      for (int i = 0; i < ar_dly; i++) begin
         #1;
         chk("ar_valid_wait", arvalid, 1);
         chk("ar_addr_stable", araddr, exp_addr);
         tick();
      end
      arready = 1'b1;
      #1;
      chk("ar_valid", arvalid, 1);
      chk("ar_addr", araddr, exp_addr);
      chk("ar_len", arlen, 3);
      chk("ar_size", arsize, 3);
      chk("ar_burst", arburst, 1);
      chk("ar_id", arid, 1);
      chk("r_ready_early", rready, 0);
      tick();
      arready = 1'b0;
      for (int b = 0; b < nbeats; b++) begin
         if (b == 1) begin
            rvalid = 1'b0;
            #1;
            chk("r_ready", rready, 1);
            chk("fill_rvalid_gap", fill_rvalid, 0);
            tick();
         end
         rvalid = 1'b1;
         rdata  = base + 64'(b);
         rlast  = (b == nbeats - 1);
         rresp  = (b == err_beat) ? 2'b11 : 2'b00;
         rid    = 4'd1;
         #1;
         chk("fill_rvalid", fill_rvalid, 1);
         chk("fill_rdata", fill_rdata, base + 64'(b));
         chk("fill_rlast", fill_rlast, (b == nbeats - 1));
         chk("fill_done", fill_done, (b == nbeats - 1));
         chk("one_outstanding_wb", wb_gnt, 0);
         if (b == nbeats - 1) chk("fill_err", fill_err, exp_err);
         tick();
      end
      rvalid = 1'b0;
      rlast  = 1'b0;
      rresp  = 2'b00;
      #1;
      chk("r_ready_idle", rready, 0);
      chk("fill_rvalid_idle", fill_rvalid, 0);
   endtask

   initial begin
      logic [31:0] ra;
      logic [63:0] rb;
      bit          both;

      // Reset state
      #2;
      chk("rst_valids", {awvalid, wvalid, bready, arvalid, rready}, 0);
      chk("rst_pulses", {wb_gnt, fill_gnt, wb_wbeat, wb_done, wb_err,
                         fill_rvalid, fill_rlast, fill_done, fill_err}, 0);
      chk("rst_addr", awaddr, 0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // Fill only, unaligned address
      fill_req  = 1'b1;
      fill_addr = 32'h0000_1234;
      #1;
      chk("fill_gnt", fill_gnt, 1);
      chk("wb_gnt_none", wb_gnt, 0);
      tick();
      fill_req = 1'b0;
      chk("fill_gnt_pulse", fill_gnt, 0);
      axi_read(32'h0000_1220, 64'hA000_0000_0000_0000, 2, 4, -1, 0);

      // Simultaneous requests: writeback first, fill waits
      tick();
      wb_req    = 1'b1;
      wb_addr   = 32'h0000_2000;
      fill_req  = 1'b1;
      fill_addr = 32'h0000_3000;
      #1;
      chk("prio_wb_gnt", wb_gnt, 1);
      chk("prio_fill_wait", fill_gnt, 0);
      tick();
      wb_req = 1'b0;
      axi_write(32'h0000_2000, 64'hB000_0000_0000_0010, 0, 0, 2'b00, 4'd0, 0);
      chk("fill_after_wb", fill_gnt, 1);
      tick();
      fill_req = 1'b0;
      axi_read(32'h0000_3000, 64'hC000_0000_0000_0020, 0, 4, -1, 0);

      // Backpressure on AW and W
      tick();
      wb_req  = 1'b1;
      wb_addr = 32'h0000_5008;
      #1;
      chk("bp_wb_gnt", wb_gnt, 1);
      tick();
      wb_req = 1'b0;
      axi_write(32'h0000_5000, 64'hD000_0000_0000_0030, 5, 1, 2'b00, 4'd0, 0);

      // Error responses
      tick();
      wb_req  = 1'b1;
      wb_addr = 32'h0000_6000;
      #1;
      chk("err_wb_gnt", wb_gnt, 1);
      tick();
      wb_req = 1'b0;
      axi_write(32'h0000_6000, 64'h1, 1, 0, 2'b10, 4'd0, 1);
      tick();
      wb_req  = 1'b1;
      wb_addr = 32'h0000_6040;
      #1;
      tick();
      wb_req = 1'b0;
      axi_write(32'h0000_6040, 64'h2, 0, 0, 2'b00, 4'd3, 1);
      tick();
      fill_req  = 1'b1;
      fill_addr = 32'h0000_7000;
      #1;
      tick();
      fill_req = 1'b0;
      axi_read(32'h0000_7000, 64'h3, 0, 4, 1, 1);
      tick();
      fill_req  = 1'b1;
      fill_addr = 32'h0000_7020;
      #1;
      tick();
      fill_req = 1'b0;
      axi_read(32'h0000_7020, 64'h4, 0, 3, -1, 1);

      // Reset during W beat 2
      tick();
      wb_req  = 1'b1;
      wb_addr = 32'h0000_8000;
      #1;
      chk("rst_wb_gnt", wb_gnt, 1);
      tick();
      wb_req  = 1'b0;
      awready = 1'b1;
      tick();
      awready = 1'b0;
      wready  = 1'b1;
      #1;
      chk("rst_beat1", wb_wbeat, 1);
      tick();
      #1;
      chk("rst_beat2_valid", wvalid, 1);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_valids", {awvalid, wvalid, bready, arvalid, rready}, 0);
      chk("rst_mid_pulses", {wb_gnt, fill_gnt, wb_wbeat, wb_done, fill_rvalid, fill_done}, 0);
      wready = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      fill_req  = 1'b1;
      fill_addr = 32'h0000_9010;
      #1;
      chk("post_rst_fill_gnt", fill_gnt, 1);
      tick();
      fill_req = 1'b0;
      axi_read(32'h0000_9000, 64'hE000_0000_0000_0040, 1, 4, -1, 0);

      // Randomised request stream
      for (int it = 0; it < 6; it++) begin
         tick();
         both      = 1'($urandom_range(0, 1));
         ra        = $urandom;
         rb        = {$urandom, $urandom};
         fill_req  = 1'b1;
         fill_addr = ra ^ 32'h0000_0f00;
         wb_req    = both;
         wb_addr   = ra;
         #1;
         chk("rnd_wb_gnt", wb_gnt, both);
         chk("rnd_fill_gnt", fill_gnt, !both);
         tick();
         if (both) begin
            wb_req = 1'b0;
            axi_write(ra & 32'hffff_ffe0, rb, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      2'b00, 4'd0, 0);
            chk("rnd_fill_after_wb", fill_gnt, 1);
            tick();
         end
         fill_req = 1'b0;
         axi_read((ra ^ 32'h0000_0f00) & 32'hffff_ffe0, ~rb, int'($urandom_range(0, 3)), 4, -1, 0);
      end

      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
